// File: rtl/dac_piso_tx.sv
// rtl/dac_piso_tx.sv - Parallel-in serial-out transmitter for an SPI-style DAC.
// MSB first; data changes on the sclk falling edge, the DAC samples on the rising edge.
module dac_piso_tx #(
    parameter int Width  = 16,
    parameter int ClkDiv = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] din_i,
    output logic             sclk_o,
    output logic             cs_o,
    output logic             mosi_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int BitW = $clog2(Width);
    localparam logic [7:0]      DivLast = 8'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(Width - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t            state_q;
    logic [7:0]        div_q;
    logic [BitW-1:0]   bit_q;
    logic [Width-1:0]  shreg_q;
    logic              sclk_q, cs_q, mosi_q, busy_q, done_q;
    logic              div_last;

    assign div_last = (div_q == DivLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= SETUP;
                        shreg_q <= din_i;
                        div_q   <= '0;
                        bit_q   <= '0;
                        cs_q    <= 1'b0;
                        mosi_q  <= din_i[Width-1];
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        state_q <= SHIFT;
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            // The last bit is held through HOLD, so no shift after it.
                            if (bit_q != BitLast) begin
                                shreg_q <= shreg_q << 1;
                                mosi_q  <= shreg_q[Width-2];
                            end
                        end else if (bit_q == BitLast) begin
                            state_q <= HOLD;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            sclk_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        state_q <= DONE;
                        div_q   <= '0;
                        cs_q    <= 1'b1;
                        mosi_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    shreg_q <= '0;
                    bit_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk_o = sclk_q;
    assign cs_o   = cs_q;
    assign mosi_o = mosi_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_dac_piso_tx.sv
// tb/tb_dac_piso_tx.sv - Randomized self-checking bench for dac_piso_tx.
// Two instances: default (16-bit, div 4) and small (8-bit, div 2).
module tb_dac_piso_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start16 = 1'b0, start8 = 1'b0;
    logic [15:0] din16 = '0;
    logic [7:0]  din8 = '0;
    logic        sclk16, cs16, mosi16, busy16, done16;
    logic        sclk8, cs8, mosi8, busy8, done8;
    logic        sel8 = 1'b0;
    logic        o_sclk, o_cs, o_mosi, o_busy, o_done;
    int          n_checks = 0, n_fail = 0;
    int          viol16 = 0, viol8 = 0;
    logic        ps16 = 0, pc16 = 1, pm16 = 0, ps8 = 0, pc8 = 1, pm8 = 0;

    always #5 clk = ~clk;

    dac_piso_tx u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .din_i(din16),
        .sclk_o(sclk16), .cs_o(cs16), .mosi_o(mosi16), .busy_o(busy16), .done_o(done16)
    );

    dac_piso_tx #(.Width(8), .ClkDiv(2)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .din_i(din8),
        .sclk_o(sclk8), .cs_o(cs8), .mosi_o(mosi8), .busy_o(busy8), .done_o(done8)
    );

    assign o_sclk = sel8 ? sclk8 : sclk16;
    assign o_cs   = sel8 ? cs8   : cs16;
    assign o_mosi = sel8 ? mosi8 : mosi16;
    assign o_busy = sel8 ? busy8 : busy16;
    assign o_done = sel8 ? done8 : done16;

    // Line rules: data stable while sclk high, no sclk activity while deselected.
    always @(negedge clk) begin
        if (!rst) begin
            if (ps16 && sclk16 && (mosi16 != pm16)) viol16++;
            if (pc16 && cs16 && (sclk16 != ps16)) viol16++;
            if (ps8 && sclk8 && (mosi8 != pm8)) viol8++;
            if (pc8 && cs8 && (sclk8 != ps8)) viol8++;
        end
        ps16 = sclk16; pc16 = cs16; pm16 = mosi16;
        ps8  = sclk8;  pc8  = cs8;  pm8  = mosi8;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic [31:0] w);
        if (sel8) begin
            start8 = s; din8 = w[7:0];
        end else begin
            start16 = s; din16 = w[15:0];
        end
    endtask

    // Runs one transfer from a negedge; returns at the first IDLE negedge afterwards.
    task automatic xfer(input string tag, input logic [31:0] word, input int w, input int d,
                        input bit keep, input logic [31:0] next_word,
                        input int inj, input logic [31:0] inj_word);
        logic [31:0] cap = '0, mask;
        int nb = 0, nc = 0, nd = 0, nr = 0, first_rise = -1, last_rise = -1, bad_gap = 0;
        logic prev_s = 1'b0, first_busy = 1'b0;
        bit seen = 0, ended = 0;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        set_in(1'b1, word);
        @(negedge clk);
        set_in(keep, keep ? next_word : word);
        for (int i = 0; i < 3000; i++) begin
            if (i == 0) first_busy = o_busy;
            if (i == inj) set_in(1'b1, inj_word);
            if (i == inj + 1) set_in(1'b0, word);
            if (o_busy) begin seen = 1; nb++; end
            if (!o_cs) nc++;
            if (o_done) nd++;
            if (o_sclk && !prev_s) begin
                nr++;
                cap = {cap[30:0], o_mosi};
                if (first_rise < 0) first_rise = i;
                else if (i - last_rise != 2 * d) bad_gap++;
                last_rise = i;
            end
            prev_s = o_sclk;
            if (seen && !o_busy) begin ended = 1; break; end
            @(negedge clk);
        end
        check({tag, "_accept"}, 32'(first_busy), 1);
        check({tag, "_ended"}, 32'(ended), 1);
        check({tag, "_busy_cycles"}, nb, d * (2 * w + 2) + 1);
        check({tag, "_cs_low"}, nc, d * (2 * w + 2));
        check({tag, "_done_cnt"}, nd, 1);
        check({tag, "_rises"}, nr, w);
        check({tag, "_first_rise"}, first_rise, d);
        check({tag, "_gap"}, bad_gap, 0);
        check({tag, "_word"}, cap & mask, word & mask);
        check({tag, "_idle_cs"}, 32'(o_cs), 1);
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_busy || o_done || !o_cs || o_sclk || o_mosi) bad++;
        end
        check({tag, "_idle"}, bad, 0);
    endtask

    initial begin
        logic [31:0] w;
        int inj, nd;
        repeat (3) @(negedge clk);
        check("rst_cs16", 32'(cs16), 1);
        check("rst_sclk16", 32'(sclk16), 0);
        check("rst_mosi16", 32'(mosi16), 0);
        check("rst_busy16", 32'(busy16), 0);
        check("rst_done16", 32'(done16), 0);
        check("rst_cs8", 32'(cs8), 1);
        check("rst_busy8", 32'(busy8), 0);
        rst = 1'b0;
        @(negedge clk);

        sel8 = 1'b0;
        xfer("a5c3", 32'hA5C3, 16, 4, 0, 0, -1, 0);
        idle_check("a5c3", 5);

        xfer("b2b_0001", 32'h0001, 16, 4, 1, 32'hFFFF, -1, 0);
        xfer("b2b_ffff", 32'hFFFF, 16, 4, 0, 0, -1, 0);
        idle_check("b2b", 5);

        for (int k = 0; k < 3; k++) begin
            w   = $urandom & 32'hFFFF;
            inj = $urandom_range(6, 4 + 2 * 16 * 4 - 4);
            xfer("inj", w, 16, 4, 0, 0, inj, ~w);
            idle_check("inj", 150);
        end

        for (int k = 0; k < 4; k++) begin
            xfer("rnd16", $urandom & 32'hFFFF, 16, 4, 0, 0, -1, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        set_in(1'b1, 32'hBEEF);
        @(negedge clk);
        set_in(1'b0, 32'hBEEF);
        repeat (61) @(negedge clk);
        check("pre_rst_cs", 32'(cs16), 0);
        #2 rst = 1'b1;
        #1;
        check("async_cs", 32'(cs16), 1);
        check("async_sclk", 32'(sclk16), 0);
        check("async_busy", 32'(busy16), 0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done16) nd++;
        end
        rst = 1'b0;
        idle_check("post_rst", 150);
        check("rst_no_done", nd, 0);
        xfer("x1234", 32'h1234, 16, 4, 0, 0, -1, 0);

        sel8 = 1'b1;
        @(negedge clk);
        xfer("x81", 32'h81, 8, 2, 0, 0, -1, 0);
        for (int k = 0; k < 3; k++) begin
            xfer("rnd8", $urandom & 32'hFF, 8, 2, 0, 0, -1, 0);
        end
        w = $urandom & 32'hFF;
        xfer("inj8", w, 8, 2, 0, 0, $urandom_range(4, 30), ~w);
        idle_check("inj8", 40);

        check("mon16", viol16, 0);
        check("mon8", viol8, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
